// File: rtl/register_scoreboard_if.sv
// register_scoreboard_if: issue/control inputs and per-register status outputs of the scoreboard
interface register_scoreboard_if;
  logic       issue_valid;
  logic       issue_we;
  logic [2:0] issue_rd;
  logic       freeze;
  logic       flush;
  logic [2:0] register_invalid [7:0];
  logic       pending;
  logic [3:0] pending_count;
  modport master (output issue_valid, issue_we, issue_rd, freeze, flush, input register_invalid, pending, pending_count);
  modport slave (input issue_valid, issue_we, issue_rd, freeze, flush, output register_invalid, pending, pending_count);
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register countdown of in-flight writes (3=EX, 2=MEM, 1=WB, 0=none)
module register_scoreboard #(
  parameter int NREG = 8,
  parameter int DEPTH = 3
) (
  input logic clk,
  input logic reset,
  register_scoreboard_if.slave sb
);
  localparam logic [2:0] D = 3'(DEPTH);
  logic [2:0] cnt [NREG];
  logic       issue;
  assign issue = sb.issue_valid && sb.issue_we && !sb.flush;
  genvar i;
  for (i = 0; i < NREG; i++) begin : g_entry
    always_ff @(posedge clk)
      if (reset) cnt[i] <= '0;
      else if (!sb.freeze)
        cnt[i] <= issue && sb.issue_rd == 3'(i) ? D :
                  sb.flush && cnt[i] == D ? 3'd0 :
                  cnt[i] != 3'd0 ? cnt[i] - 3'd1 : 3'd0;
    assign sb.register_invalid[i] = cnt[i];
  end
  always_comb begin
    sb.pending_count = '0;
    for (int r = 0; r < NREG; r++) sb.pending_count = sb.pending_count + 4'(cnt[r] != 3'd0);
  end
  assign sb.pending = sb.pending_count != 4'd0;
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed vectors push expected entry snapshots; a monitor pops and compares each cycle
module tb_register_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  register_scoreboard_if sb();
  register_scoreboard dut (.clk(clk), .reset(reset), .sb(sb));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic v, input logic w, input logic [2:0] d,
                      input logic fz, input logic fl, input logic [31:0] e);
    @(negedge clk);
    reset = r;
    sb.issue_valid = v;
    sb.issue_we = w;
    sb.issue_rd = d;
    sb.freeze = fz;
    sb.flush = fl;
    exp_q.push_back(e);
  endtask
  task automatic idle(input logic [31:0] e);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, e);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [31:0] e, got;
      logic [3:0] n;
      e = exp_q.pop_front();
      n = '0;
      got = '0;
      for (int r = 0; r < 8; r++) begin
        got[r*4 +: 4] = {1'b0, sb.register_invalid[r]};
        if (e[r*4 +: 4] != 4'd0) n = n + 4'd1;
      end
      checks++;
      if (got !== e) begin errors++; $display("FAIL entries: got %h expected %h", got, e); end
      checks++;
      if (sb.pending_count !== n) begin errors++; $display("FAIL pending_count: got %0d expected %0d (entries %h)", sb.pending_count, n, e); end
      checks++;
      if (sb.pending !== (n != 4'd0)) begin errors++; $display("FAIL pending: got %b expected %b (entries %h)", sb.pending, n != 4'd0, e); end
    end
  end
  initial begin
    sb.issue_valid = 1'b0; sb.issue_we = 1'b0; sb.issue_rd = '0; sb.freeze = 1'b0; sb.flush = 1'b0;
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h00000000);
    // single issue to r5, then valid without write-enable changes nothing
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 32'h00300000);
    idle(32'h00200000);
    idle(32'h00100000);
    idle(32'h00000000);
    step(1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 32'h00000000);
    // back-to-back writes to r2 restart the count
    step(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 32'h00000300);
    step(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 32'h00000300);
    idle(32'h00000200);
    idle(32'h00000100);
    idle(32'h00000000);
    // overlapping r1, r3, r4
    step(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h00000030);
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 32'h00003020);
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 32'h00032010);
    idle(32'h00021000);
    idle(32'h00010000);
    idle(32'h00000000);
    // flush kills r6 in EX, ignores r7 issue, r0 keeps aging
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h00000003);
    step(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 32'h03000002);
    step(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 32'h00000001);
    idle(32'h00000000);
    // freeze holds everything, beats issue and flush
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h00000003);
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 32'h00000003);
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 32'h00000003);
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 32'h00000003);
    step(1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 32'h00000003);
    idle(32'h00000002);
    idle(32'h00000001);
    idle(32'h00000000);
    // reset beats a concurrent issue
    step(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h00000030);
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 32'h00030020);
    step(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 32'h03020010);
    step(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 32'h00000000);
    idle(32'h00000000);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain: %0d expected snapshots left unchecked, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
